// File: rtl/numparse.sv
// rtl/numparse.sv - one-char-per-cycle string-to-integer parser with memory read master
// Skips spaces, takes an optional sign, accumulates digits in radix 2..36 with saturation.
module numparse #(
  parameter int ASZ  = 17,
  parameter int DSZ  = 32,
  parameter int LMAX = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           st,
  input  logic [5:0]     base,
  input  logic [ASZ-1:0] tib,
  input  logic [7:0]     ch,
  output logic [ASZ-1:0] ma,
  output logic           bsy,
  output logic           done,
  output logic [DSZ-1:0] vo,
  output logic           ok,
  output logic           ovf,
  output logic [ASZ-1:0] ea
);

  localparam int CW = $clog2(LMAX + 1);
  localparam int PW = DSZ + 7;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_LEAD, S_DIG, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [ASZ-1:0] ma_q, ma_d, ea_q, ea_d;
  logic [5:0]     base_q, base_d;
  logic [DSZ:0]   acc_q, acc_d;
  logic           neg_q, neg_d, nd_q, nd_d, sovf_q, sovf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bsy_q, bsy_d, done_q, done_d, ok_q, ok_d, ovf_q, ovf_d;
  logic [DSZ-1:0] vo_q, vo_d;

  logic [5:0]     dv;
  logic           dvalid, step_ovf, term, abort, term_ch;
  logic [DSZ:0]   lim;
  logic [DSZ-1:0] nacc;
  logic [PW-1:0]  prod;

  // Returns 63 for anything that is not an alphanumeric, which no radix accepts.
  function automatic logic [5:0] digit_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return c[5:0] - 6'h30;
    else if (c >= 8'h61 && c <= 8'h7a) return c[5:0] - 6'h17;
    else if (c >= 8'h41 && c <= 8'h5a) return c[5:0] + 6'h09;
    else                               return 6'h3f;
  endfunction

  always_comb begin
    dv       = digit_val(ch);
    dvalid   = dv < base_q;
    term_ch  = (ch == 8'h00) || (ch == 8'h20);
    lim      = '0;
    lim[DSZ-1] = 1'b1;
    if (!neg_q) lim = lim - (DSZ+1)'(1);
    prod     = PW'(acc_q) * PW'(base_q) + PW'(dv);
    step_ovf = prod > PW'(lim);
    nacc     = '0 - acc_q[DSZ-1:0];

    state_d = state_q;
    ma_d    = ma_q;
    base_d  = base_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    nd_d    = nd_q;
    sovf_d  = sovf_q;
    cnt_d   = cnt_q;
    vo_d    = vo_q;
    ok_d    = ok_q;
    ovf_d   = ovf_q;
    ea_d    = ea_q;
    term    = 1'b0;
    abort   = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (st) begin
          if (base >= 6'd2 && base <= 6'd36) begin
            state_d = S_FILL;
            ma_d    = tib;
            base_d  = base;
            acc_d   = '0;
            neg_d   = 1'b0;
            nd_d    = 1'b0;
            sovf_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            vo_d    = '0;
            ok_d    = 1'b0;
            ovf_d   = 1'b0;
            ea_d    = tib;
          end
        end
        S_FILL: begin
          ma_d    = ma_q + ASZ'(1);
          state_d = S_LEAD;
        end
        S_LEAD: begin
          ma_d = ma_q + ASZ'(1);
          if (ch != 8'h20) begin
            cnt_d = CW'(1);
            if (ch == 8'h2d || ch == 8'h2b) begin
              neg_d   = (ch == 8'h2d);
              state_d = S_DIG;
            end else if (dvalid) begin
              acc_d   = (DSZ+1)'(dv);
              nd_d    = 1'b1;
              state_d = S_DIG;
            end else begin
              term = 1'b1;
            end
          end
        end
        S_DIG: begin
          ma_d = ma_q + ASZ'(1);
          if (cnt_q == CW'(LMAX)) begin
            term  = 1'b1;
            abort = 1'b1;
          end else if (dvalid) begin
            cnt_d = cnt_q + CW'(1);
            nd_d  = 1'b1;
            // Once over the limit the accumulator parks there; the sticky flag remembers why.
            acc_d = step_ovf ? lim : prod[DSZ:0];
            if (step_ovf) sovf_d = 1'b1;
          end else begin
            term = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    if (term) begin
      state_d = S_DONE;
      ma_d    = ma_q;
      ea_d    = ma_q - ASZ'(1);
      ok_d    = nd_q && !sovf_q && term_ch && !abort;
      ovf_d   = sovf_q;
      if (sovf_q) vo_d = neg_q ? {1'b1, {(DSZ-1){1'b0}}} : {1'b0, {(DSZ-1){1'b1}}};
      else        vo_d = neg_q ? nacc : acc_q[DSZ-1:0];
    end

    bsy_d  = (state_d == S_FILL) || (state_d == S_LEAD) || (state_d == S_DIG);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ma_q    <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      nd_q    <= 1'b0;
      sovf_q  <= 1'b0;
      cnt_q   <= '0;
      bsy_q   <= 1'b0;
      done_q  <= 1'b0;
      vo_q    <= '0;
      ok_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ea_q    <= '0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      nd_q    <= nd_d;
      sovf_q  <= sovf_d;
      cnt_q   <= cnt_d;
      bsy_q   <= bsy_d;
      done_q  <= done_d;
      vo_q    <= vo_d;
      ok_q    <= ok_d;
      ovf_q   <= ovf_d;
      ea_q    <= ea_d;
    end
  end

  assign ma   = ma_q;
  assign bsy  = bsy_q;
  assign done = done_q;
  assign vo   = vo_q;
  assign ok   = ok_q;
  assign ovf  = ovf_q;
  assign ea   = ea_q;

endmodule
